// File: rtl/bootdata_sender.sv
// ----------------------------------------------------------------------------
// bootdata_sender
//
// Host-side initiator of the 32-bit bootdata req/ack interface used by the
// cartridge ROM loader. A transfer starts with a loader reset pulse. The byte
// stream from the file source is then packed big-endian into 32-bit words,
// and each word is handed over through a level req/ack handshake. After each
// ack falls, a recovery gap gives the loader time to finish its SRAM write
// burst before the next request.
//
// Optional build macro:
//   BOOTDATA_SENDER_CHECKSUM_EN  - when defined, checksum is the mod-256 sum
//                                  of all accepted source bytes (pad bytes
//                                  excluded), cleared on start. When it is
//                                  not defined, checksum is tied to zero.
//
// Ports:
//   clk                  system clock
//   reset                synchronous, active-high reset
//   start                pulse that begins a transfer (accepted in IDLE only)
//   size_in[15:0]        ROM byte count, sampled on start
//   byte_data[7:0]       source byte
//   byte_valid           source byte available
//   byte_ready           a byte is accepted when byte_valid && byte_ready
//   host_bootdata[31:0]  packed word to the loader
//   host_bootdata_req    word-valid request
//   host_bootdata_ack    loader acknowledge (level sensitive)
//   host_bootdata_reset  loader reset, high for RST_CYCLES at transfer start
//   host_bootdata_size   latched ROM size
//   busy                 transfer in progress
//   done                 one-cycle pulse at completion (with or without error)
//   error                sticky ack-timeout flag, cleared by the next start
//   words_sent[13:0]     acknowledged words, saturating
//   checksum[7:0]        byte checksum (see the optional build macro above)
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_RST   | loader reset held high for RST_CYCLES
//   ST_FILL  | collecting up to 4 source bytes; pads a short word on exit
//   ST_REQ   | req high, waiting for ack (with timeout)
//   ST_ACKLO | waiting for ack to return low (with timeout)
//   ST_GAP   | loader recovery gap of GAP_CYCLES
//   ST_FIN   | one-cycle done pulse
// ----------------------------------------------------------------------------
module bootdata_sender #(
    parameter int unsigned RST_CYCLES  = 8,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter logic [7:0]  PAD_BYTE    = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] size_in,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] host_bootdata,
    output logic        host_bootdata_req,
    input  logic        host_bootdata_ack,
    output logic        host_bootdata_reset,
    output logic [15:0] host_bootdata_size,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [13:0] words_sent,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_FILL  = 3'd2,
        ST_REQ   = 3'd3,
        ST_ACKLO = 3'd4,
        ST_GAP   = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    // A single down-counter serves the reset pulse, the ack timeouts and the
    // gap. It is sized for the longest of the three intervals.
    localparam int unsigned MAX_RG  = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_RG > ACK_TIMEOUT) ? MAX_RG : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Each interval of N cycles loads N-1 and ends when the counter reads 0.
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'((RST_CYCLES  > 0) ? RST_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [15:0]       remain_q, remain_d;
    logic [2:0]        slot_q,  slot_d;
    logic [31:0]       word_q,  word_d;
    logic [15:0]       size_q,  size_d;
    logic [13:0]       words_q, words_d;
    logic              err_q,   err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            remain_q <= '0;
            slot_q   <= '0;
            word_q   <= '0;
            size_q   <= '0;
            words_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
            slot_q   <= slot_d;
            word_q   <= word_d;
            size_q   <= size_d;
            words_q  <= words_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        remain_d   = remain_q;
        slot_d     = slot_q;
        word_d     = word_q;
        size_d     = size_q;
        words_d    = words_q;
        err_d      = err_q;
        byte_ready = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d   = size_in;
                    remain_d = size_in;
                    err_d    = 1'b0;
                    words_d  = '0;
                    cnt_d    = RST_LOAD;
                    state_d  = ST_RST;
                end
            end

            ST_RST: begin
                if (cnt_q == '0) begin
                    if (remain_q == 16'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        slot_d  = 3'd0;
                        state_d = ST_FILL;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_FILL: begin
                if (slot_q == 3'd4 || remain_q == 16'd0) begin
                    // Word complete or stream exhausted: fill the unused low
                    // slots with the pad byte and present the word.
                    for (int i = 0; i < 4; i++) begin
                        if (3'(i) >= slot_q) begin
                            word_d[31 - 8*i -: 8] = PAD_BYTE;
                        end
                    end
                    cnt_d   = ACK_LOAD;
                    state_d = ST_REQ;
                end else begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        // Slot 0 is the most significant byte (big-endian).
                        for (int i = 0; i < 4; i++) begin
                            if (slot_q == 3'(i)) begin
                                word_d[31 - 8*i -: 8] = byte_data;
                            end
                        end
                        slot_d   = slot_q + 3'd1;
                        remain_d = remain_q - 16'd1;
                    end
                end
            end

            ST_REQ: begin
                // Level sensitive: an ack already high on entry counts.
                if (host_bootdata_ack) begin
                    words_d = (words_q == 14'h3FFF) ? words_q : words_q + 14'd1;
                    cnt_d   = ACK_LOAD;
                    state_d = ST_ACKLO;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_ACKLO: begin
                if (!host_bootdata_ack) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (remain_q != 16'd0) begin
                        slot_d  = 3'd0;
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign host_bootdata       = word_q;
    assign host_bootdata_req   = (state_q == ST_REQ);
    assign host_bootdata_reset = (state_q == ST_RST);
    assign host_bootdata_size  = size_q;
    assign busy                = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done                = (state_q == ST_FIN);
    assign error               = err_q;
    assign words_sent          = words_q;

`ifdef BOOTDATA_SENDER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE && start) begin
            csum_d = 8'h00;
        end else if (byte_ready && byte_valid) begin
            csum_d = csum_q + byte_data;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_bootdata_sender.sv
// ----------------------------------------------------------------------------
// tb_bootdata_sender
//
// Directed and randomised transfers through bootdata_sender. A loader model
// acknowledges requests with configurable latency and hold time, and a byte
// source feeds a queue with optional random or directed stalls. Expected
// words, counts and checksum come from a byte-list model of the transfer.
// All sampling and driving happens on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_bootdata_sender;

    localparam int         RST_CYCLES  = 8;
    localparam int         GAP_CYCLES  = 16;
    localparam int         ACK_TIMEOUT = 1024;
    localparam logic [7:0] PAD_BYTE    = 8'hFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] size_in;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack;
    logic        host_bootdata_reset;
    logic [15:0] host_bootdata_size;
    logic        busy;
    logic        done;
    logic        error;
    logic [13:0] words_sent;
    logic [7:0]  checksum;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] src_q[$];

    int ack_lat;
    int ack_hold;
    int stall_at;
    int stall_len;
    int stall_pct;
    bit no_ack;
    bit spur_start;

    always #5 clk = ~clk;

    bootdata_sender #(
        .RST_CYCLES (RST_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .PAD_BYTE   (PAD_BYTE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .size_in            (size_in),
        .byte_data          (byte_data),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .host_bootdata      (host_bootdata),
        .host_bootdata_req  (host_bootdata_req),
        .host_bootdata_ack  (host_bootdata_ack),
        .host_bootdata_reset(host_bootdata_reset),
        .host_bootdata_size (host_bootdata_size),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .words_sent         (words_sent),
        .checksum           (checksum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer of sz bytes taken from src_q, with the loader
    // and source behaviour set by ack_lat, ack_hold, no_ack and stall_*.
    task automatic run_xfer(input string name, input int sz);
        logic [7:0]  bytes[$];
        logic [31:0] exp_words[$];
        logic [31:0] got_words[$];
        logic [31:0] w;
        logic [31:0] held;
        logic [31:0] stall_word;
        logic [7:0]  exp_sum;
        int n, fall_n, rst_len, req_len, done_cnt, post_done;
        int acc_n, stall_left, hold_left, wait_c, n_acc_exp, exp_nwords, exp_ws;
        bit watching, req_prev;

        bytes = src_q;
        for (int i = 0; i < sz; i += 4) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                w = (w << 8) | 32'((i + j < sz) ? bytes[i + j] : PAD_BYTE);
            end
            exp_words.push_back(w);
        end
        n_acc_exp  = no_ack ? ((sz < 4) ? sz : 4) : sz;
        exp_nwords = no_ack ? ((sz > 0) ? 1 : 0) : exp_words.size();
        exp_ws     = no_ack ? 0 : exp_words.size();
        exp_sum    = 8'h00;
`ifdef BOOTDATA_SENDER_CHECKSUM_EN
        for (int i = 0; i < n_acc_exp; i++) exp_sum = exp_sum + bytes[i];
`endif

        size_in = 16'(sz);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check({name, ".busy_after_start"}, busy, 1);
        check({name, ".error_cleared"}, error, 0);
        check({name, ".words_cleared"}, words_sent, 0);
        check({name, ".checksum_cleared"}, checksum, 0);
        check({name, ".size_latched"}, host_bootdata_size, sz);

        n = 0; fall_n = 0; rst_len = 0; req_len = 0; done_cnt = 0; post_done = 0;
        acc_n = 0; stall_left = stall_len; hold_left = 0; wait_c = 0;
        watching = 1'b0; req_prev = 1'b0; held = 32'h0; stall_word = 32'h0;

        while (post_done < 3 && n < 4000) begin
            if (host_bootdata_reset) rst_len++;
            if (host_bootdata_req) begin
                req_len++;
                if (!req_prev) begin
                    got_words.push_back(host_bootdata);
                    held = host_bootdata;
                end else begin
                    check({name, ".word_stable"}, host_bootdata, held);
                end
            end
            req_prev = host_bootdata_req;

            if (watching && byte_ready) begin
                check({name, ".ack_low_to_fill"}, n - fall_n, GAP_CYCLES + 1);
                watching = 1'b0;
            end

            if (done) begin
                done_cnt++;
                watching = 1'b0;
                if (done_cnt == 1) begin
                    check({name, ".busy_at_done"}, busy, 0);
                    check({name, ".words_sent"}, words_sent, exp_ws);
                    check({name, ".error_at_done"}, error, no_ack);
                    check({name, ".checksum"}, checksum, exp_sum);
                    check({name, ".size_held"}, host_bootdata_size, sz);
                end
            end
            if (done_cnt > 0) post_done++;

            // loader model
            if (host_bootdata_ack) begin
                hold_left--;
                if (hold_left <= 0) begin
                    host_bootdata_ack = 1'b0;
                    fall_n   = n;
                    watching = 1'b1;
                end
            end else if (host_bootdata_req && !no_ack) begin
                if (wait_c >= ack_lat) begin
                    host_bootdata_ack = 1'b1;
                    hold_left = ack_hold;
                    wait_c    = 0;
                end else begin
                    wait_c++;
                end
            end else begin
                wait_c = 0;
            end

            // byte source
            if (stall_at >= 0 && acc_n == stall_at && stall_left > 0) begin
                if (stall_left == stall_len) begin
                    stall_word = host_bootdata;
                end else begin
                    check({name, ".stall_word"}, host_bootdata, stall_word);
                    check({name, ".stall_req"}, host_bootdata_req, 0);
                end
                byte_valid = 1'b0;
                stall_left--;
            end else if (src_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
                byte_valid = 1'b1;
                byte_data  = src_q[0];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end
            if (byte_valid && byte_ready) begin
                void'(src_q.pop_front());
                acc_n++;
            end

            if (spur_start && n == 20) begin
                start   = 1'b1;
                size_in = 16'h1234;
            end else if (spur_start && n == 21) begin
                start = 1'b0;
                check({name, ".start_ignored_size"}, host_bootdata_size, sz);
            end

            n++;
            @(negedge clk);
        end

        byte_valid = 1'b0;
        check({name, ".done_pulses"}, done_cnt, 1);
        check({name, ".rst_len"}, rst_len, RST_CYCLES);
        check({name, ".word_count"}, got_words.size(), exp_nwords);
        for (int i = 0; i < got_words.size() && i < exp_nwords; i++) begin
            check($sformatf("%s.word%0d", name, i), got_words[i], exp_words[i]);
        end
        if (no_ack) check({name, ".req_timeout_len"}, req_len, ACK_TIMEOUT);
        check({name, ".error_sticky"}, error, no_ack);
        src_q.delete();
    endtask

    initial begin
        int n;
        int done_seen;
        int sz;

        reset = 1'b1; start = 1'b0; size_in = 16'h0; byte_data = 8'h0;
        byte_valid = 1'b0; host_bootdata_ack = 1'b0;
        ack_lat = 0; ack_hold = 1; stall_at = -1; stall_len = 0; stall_pct = 0;
        no_ack = 1'b0; spur_start = 1'b0;

        repeat (3) @(negedge clk);
        check("reset.bootdata", host_bootdata, 0);
        check("reset.req", host_bootdata_req, 0);
        check("reset.ldr_reset", host_bootdata_reset, 0);
        check("reset.size", host_bootdata_size, 0);
        check("reset.byte_ready", byte_ready, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.error", error, 0);
        check("reset.words", words_sent, 0);
        check("reset.checksum", checksum, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle.busy", busy, 0);

        for (int i = 0; i < 8; i++) src_q.push_back(8'(i));
        run_xfer("seq8", 8);

        for (int i = 0; i < 6; i++) src_q.push_back(8'(8'hA0 + i));
        run_xfer("pad6", 6);

        run_xfer("empty", 0);

        no_ack = 1'b1;
        for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
        run_xfer("noack", 5);
        no_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("noack.error_still_set", error, 1);

        ack_hold = 3; stall_at = 2; stall_len = 50;
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
        run_xfer("hold_stall", 8);
        ack_hold = 1; stall_at = -1; stall_len = 0;

        src_q.push_back(8'h80); src_q.push_back(8'h90); src_q.push_back(8'hF0);
        run_xfer("csum3", 3);

        spur_start = 1'b1;
        for (int t = 0; t < 6; t++) begin
            sz        = $urandom_range(23, 1);
            ack_lat   = $urandom_range(3, 0);
            ack_hold  = $urandom_range(3, 1);
            stall_pct = $urandom_range(50, 0);
            for (int i = 0; i < sz; i++) src_q.push_back(8'($urandom));
            run_xfer($sformatf("rnd%0d", t), sz);
        end
        spur_start = 1'b0; ack_lat = 0; ack_hold = 1; stall_pct = 0;

        // reset while a word is being requested
        size_in = 16'd8;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!host_bootdata_req && n < 200) begin
            byte_valid = 1'b1;
            byte_data  = 8'(8'h55 + n);
            @(negedge clk);
            n++;
        end
        byte_valid = 1'b0;
        check("rstreq.req_reached", host_bootdata_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstreq.req", host_bootdata_req, 0);
        check("rstreq.busy", busy, 0);
        check("rstreq.done", done, 0);
        check("rstreq.words", words_sent, 0);
        check("rstreq.size", host_bootdata_size, 0);
        check("rstreq.bootdata", host_bootdata, 0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rstreq.no_done", done_seen, 0);
        check("rstreq.idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
